enocoro_host_ctrl: RTL and testbench

//  Host-side driver for the 8-bit Enocoro-128v2 keystream core. On start it:
//  - resets the core;
//  - serialises the 128-bit key and 64-bit IV into the core's byte-load port;
//  - captures keystream bytes on every core valid pulse;
//  - XORs them with a valid/ready plaintext byte stream to produce ciphertext.
//  It sits between the system datapath and the core. The core is never stalled.

---
 rtl/enocoro_host_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_enocoro_host_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/enocoro_host_ctrl.sv
// Host-side driver for the 8-bit Enocoro-128v2 keystream core: resets and loads the core,
// buffers its keystream bytes and XORs them onto a valid/ready plaintext stream.
module enocoro_host_ctrl #(
  parameter int unsigned KS_DEPTH = 4,
  parameter int unsigned DISCARD  = 0,
  parameter int unsigned RST_CYC  = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [127:0] key,
  input  logic [63:0]  iv,
  input  logic [15:0]  msg_len,
  output logic         busy,
  output logic         done,
  output logic         ks_ovf,
  output logic         core_rst_n,
  output logic [7:0]   core_din,
  input  logic [7:0]   core_dout,
  input  logic         core_valid,
  input  logic [7:0]   pt_data,
  input  logic         pt_valid,
  output logic         pt_ready,
  output logic [7:0]   ct_data,
  output logic         ct_valid,
  input  logic         ct_ready
);

  localparam int unsigned AW        = $clog2(KS_DEPTH);
  localparam int unsigned CNT_W     = 16;
  localparam int unsigned LOAD_LAST = 23;

  typedef enum logic [2:0] {S_IDLE, S_CRST, S_LOAD, S_WARM, S_STREAM} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [127:0]       key_q, key_d;
  logic [63:0]        iv_q, iv_d;
  logic [15:0]        rem_q, rem_d;
  logic               core_rst_n_q, core_rst_n_d;
  logic [7:0]         core_din_q, core_din_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               ks_ovf_q, ks_ovf_d;
  logic               ct_valid_q, ct_valid_d;
  logic [7:0]         ct_data_q, ct_data_d;
  logic [7:0]         mem_q [KS_DEPTH];
  logic [7:0]         mem_d [KS_DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]        fill_q, fill_d;

  logic         fifo_full, fifo_empty, pt_hs, ct_hs, ks_push, flush;
  logic [191:0] ld_vec;
  logic [4:0]   ld_idx;

  assign ld_vec     = {iv_q, key_q};
  assign ld_idx     = 5'(cnt_q + 16'd1);
  assign fifo_full  = (fill_q == (AW+1)'(KS_DEPTH));
  assign fifo_empty = (fill_q == '0);
  assign pt_ready   = (state_q == S_STREAM) && !fifo_empty && (!ct_valid_q || ct_ready)
                      && (rem_q != 16'd0);
  assign pt_hs      = pt_valid && pt_ready;
  assign ct_hs      = ct_valid_q && ct_ready;

  // Next-state, load sequencing, keystream buffering and ciphertext generation
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    key_d        = key_q;
    iv_d         = iv_q;
    rem_d        = rem_q;
    core_rst_n_d = core_rst_n_q;
    core_din_d   = 8'd0;
    done_d       = 1'b0;
    ks_ovf_d     = ks_ovf_q;
    ct_valid_d   = ct_valid_q;
    ct_data_d    = ct_data_q;
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    fill_d       = fill_q;
    ks_push      = 1'b0;
    flush        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (msg_len != 16'd0) begin
            key_d    = key;
            iv_d     = iv;
            rem_d    = msg_len;
            ks_ovf_d = 1'b0;
            cnt_d    = '0;
            state_d  = S_CRST;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_CRST: begin
        if (cnt_q == CNT_W'(RST_CYC - 1)) begin
          cnt_d        = '0;
          core_rst_n_d = 1'b1;
          core_din_d   = ld_vec[7:0];
          state_d      = S_LOAD;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_LOAD: begin
        if (cnt_q == CNT_W'(LOAD_LAST)) begin
          cnt_d   = '0;
          state_d = (DISCARD == 0) ? S_STREAM : S_WARM;
        end else begin
          cnt_d      = cnt_q + 16'd1;
          core_din_d = ld_vec[{ld_idx, 3'b000} +: 8];
        end
      end
      S_WARM: begin
        if (core_valid) begin
          if (cnt_q == CNT_W'(DISCARD - 1)) begin
            cnt_d   = '0;
            state_d = S_STREAM;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      S_STREAM: begin
        // A full FIFO still accepts a byte when the same cycle pops one
        if (core_valid) begin
          if (!fifo_full || pt_hs) ks_push = 1'b1;
          else                     ks_ovf_d = 1'b1;
        end
        if (ct_hs) ct_valid_d = 1'b0;
        if (pt_hs) begin
          ct_data_d  = pt_data ^ mem_q[rd_ptr_q];
          ct_valid_d = 1'b1;
          rem_d      = rem_q - 16'd1;
        end
        if (ct_hs && (rem_q == 16'd0)) begin
          done_d       = 1'b1;
          flush        = 1'b1;
          core_rst_n_d = 1'b0;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      fill_d   = '0;
    end else begin
      if (ks_push) begin
        mem_d[wr_ptr_q] = core_dout;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pt_hs) rd_ptr_d = rd_ptr_q + 1'b1;
      fill_d = fill_q + (AW+1)'(ks_push) - (AW+1)'(pt_hs);
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      key_q        <= '0;
      iv_q         <= '0;
      rem_q        <= '0;
      core_rst_n_q <= 1'b0;
      core_din_q   <= 8'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      ks_ovf_q     <= 1'b0;
      ct_valid_q   <= 1'b0;
      ct_data_q    <= 8'd0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fill_q       <= '0;
      for (int i = 0; i < int'(KS_DEPTH); i++) mem_q[i] <= 8'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      key_q        <= key_d;
      iv_q         <= iv_d;
      rem_q        <= rem_d;
      core_rst_n_q <= core_rst_n_d;
      core_din_q   <= core_din_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      ks_ovf_q     <= ks_ovf_d;
      ct_valid_q   <= ct_valid_d;
      ct_data_q    <= ct_data_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fill_q       <= fill_d;
      mem_q        <= mem_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign ks_ovf     = ks_ovf_q;
  assign core_rst_n = core_rst_n_q;
  assign core_din   = core_din_q;
  assign ct_data    = ct_data_q;
  assign ct_valid   = ct_valid_q;

endmodule

// File: tb/tb_enocoro_host_ctrl.sv
// Scoreboard bench for enocoro_host_ctrl: two instances (DISCARD 0 and 2) each driven by a
// stub core emitting keystream 0xA0, 0xA1, ... once every 5 cycles after loading.
module tb_enocoro_host_ctrl;

  localparam int NDUT = 2;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [127:0] key;
  logic [63:0]  iv;

  logic         start      [NDUT];
  logic [15:0]  msg_len    [NDUT];
  logic         busy       [NDUT];
  logic         done       [NDUT];
  logic         ks_ovf     [NDUT];
  logic         core_rst_n [NDUT];
  logic [7:0]   core_din   [NDUT];
  logic [7:0]   core_dout  [NDUT];
  logic         core_valid [NDUT];
  logic [7:0]   pt_data    [NDUT];
  logic         pt_valid   [NDUT];
  logic         pt_ready   [NDUT];
  logic [7:0]   ct_data    [NDUT];
  logic         ct_valid   [NDUT];
  logic         ct_ready   [NDUT];

  int nvec = 0;
  int nerr = 0;
  int done_cnt [NDUT];
  int ct_cnt   [NDUT];
  logic [7:0] exp0 [$];
  logic [7:0] exp1 [$];

  always #5 clk = ~clk;

  enocoro_host_ctrl #(.KS_DEPTH(4), .DISCARD(0), .RST_CYC(2)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .start(start[0]), .key(key), .iv(iv),
    .msg_len(msg_len[0]), .busy(busy[0]), .done(done[0]), .ks_ovf(ks_ovf[0]),
    .core_rst_n(core_rst_n[0]), .core_din(core_din[0]), .core_dout(core_dout[0]),
    .core_valid(core_valid[0]), .pt_data(pt_data[0]), .pt_valid(pt_valid[0]),
    .pt_ready(pt_ready[0]), .ct_data(ct_data[0]), .ct_valid(ct_valid[0]),
    .ct_ready(ct_ready[0]));

  enocoro_host_ctrl #(.KS_DEPTH(4), .DISCARD(2), .RST_CYC(2)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .start(start[1]), .key(key), .iv(iv),
    .msg_len(msg_len[1]), .busy(busy[1]), .done(done[1]), .ks_ovf(ks_ovf[1]),
    .core_rst_n(core_rst_n[1]), .core_din(core_din[1]), .core_dout(core_dout[1]),
    .core_valid(core_valid[1]), .pt_data(pt_data[1]), .pt_valid(pt_valid[1]),
    .pt_ready(pt_ready[1]), .ct_data(ct_data[1]), .ct_valid(ct_valid[1]),
    .ct_ready(ct_ready[1]));

  // Stub core: cyc counts cycles since core_rst_n rose; strobes at cyc 30, 35, 40, ...
  for (genvar g = 0; g < NDUT; g++) begin : g_stub
    logic [15:0] cyc;
    logic [7:0]  idx;
    always @(posedge clk) begin
      if (!core_rst_n[g]) begin
        cyc <= 16'd0;
        idx <= 8'd0;
      end else begin
        cyc <= cyc + 16'd1;
        if (core_valid[g]) idx <= idx + 8'd1;
      end
    end
    assign core_valid[g] = core_rst_n[g] && (cyc >= 16'd30) && (((cyc - 16'd30) % 16'd5) == 16'd0);
    assign core_dout[g]  = 8'hA0 + idx;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every ciphertext handshake
  always @(negedge clk) begin
    for (int d = 0; d < NDUT; d++) begin
      logic [7:0] e;
      bit have;
      have = 1'b0;
      e    = 8'd0;
      if (done[d] === 1'b1) done_cnt[d]++;
      if (ct_valid[d] === 1'b1 && ct_ready[d] === 1'b1) begin
        ct_cnt[d]++;
        if (d == 0 && exp0.size() != 0) begin have = 1'b1; e = exp0.pop_front(); end
        if (d == 1 && exp1.size() != 0) begin have = 1'b1; e = exp1.pop_front(); end
        if (have) chk($sformatf("ct_dut%0d", d), 32'(ct_data[d]), 32'(e));
        else begin
          nvec++;
          nerr++;
          $display("FAIL ct_unexpected dut%0d: got ct 0x%0h, expected no byte", d, ct_data[d]);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_start(input int d, input logic [15:0] len);
    msg_len[d] = len;
    start[d]   = 1'b1;
    step(1);
    start[d]   = 1'b0;
  endtask

  task automatic send_pt(input int d, input logic [7:0] b, input logic [7:0] e);
    bit hs;
    hs = 1'b0;
    if (d == 0) exp0.push_back(e);
    else        exp1.push_back(e);
    pt_data[d]  = b;
    pt_valid[d] = 1'b1;
    for (int t = 0; t < 300 && !hs; t++) begin
      @(negedge clk);
      hs = pt_ready[d];
      @(posedge clk);
      #2;
    end
    pt_valid[d] = 1'b0;
    if (!hs) begin
      nvec++;
      nerr++;
      $display("FAIL pt_timeout dut%0d: pt_ready stayed 0, expected 1", d);
    end
  endtask

  task automatic wait_done(input int d, input string nm);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 400 && !ok; t++) begin
      @(negedge clk);
      if (done[d] === 1'b1) ok = 1'b1;
    end
    chk(nm, 32'(ok), 32'd1);
  endtask

  task automatic chk_reset(input int d, input string nm);
    chk({nm, "_busy"},       32'(busy[d]),       32'd0);
    chk({nm, "_done"},       32'(done[d]),       32'd0);
    chk({nm, "_ks_ovf"},     32'(ks_ovf[d]),     32'd0);
    chk({nm, "_core_rst_n"}, 32'(core_rst_n[d]), 32'd0);
    chk({nm, "_core_din"},   32'(core_din[d]),   32'd0);
    chk({nm, "_ct_valid"},   32'(ct_valid[d]),   32'd0);
    chk({nm, "_ct_data"},    32'(ct_data[d]),    32'd0);
    chk({nm, "_pt_ready"},   32'(pt_ready[d]),   32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit, expected to finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nlow;
    int n0;
    bit ok;
    for (int d = 0; d < NDUT; d++) begin
      start[d] = 1'b0; msg_len[d] = 16'd0; pt_data[d] = 8'd0;
      pt_valid[d] = 1'b0; ct_ready[d] = 1'b1; done_cnt[d] = 0; ct_cnt[d] = 0;
    end
    key     = 128'h0F0E0D0C0B0A09080706050403020100;
    iv      = 64'h1716151413121110;
    reset_n = 1'b0;
    #1;
    chk_reset(0, "por0");
    chk_reset(1, "por1");
    step(3);
    reset_n = 1'b1;
    step(1);

    // Load sequence: RST_CYC low cycles, then key/IV bytes 0x00..0x17
    do_start(0, 16'd1);
    nlow = 0;
    @(negedge clk);
    for (int t = 0; t < 20 && core_rst_n[0] == 1'b0; t++) begin
      if (busy[0]) nlow++;
      @(negedge clk);
    end
    chk("crst_cycles", 32'(nlow), 32'd2);
    for (int k = 0; k < 24; k++) begin
      chk($sformatf("load_byte%0d", k), 32'(core_din[0]), 32'(k));
      @(negedge clk);
    end
    chk("din_after_load", 32'(core_din[0]), 32'd0);
    step(1);
    send_pt(0, 8'h00, 8'hA0);
    wait_done(0, "t1_done");

    // Basic 4-byte message
    step(1);
    n0 = done_cnt[0];
    do_start(0, 16'd4);
    send_pt(0, 8'h00, 8'hA0);
    send_pt(0, 8'h01, 8'hA0);
    send_pt(0, 8'h02, 8'hA0);
    send_pt(0, 8'h03, 8'hA0);
    wait_done(0, "t2_done");
    @(negedge clk);
    chk("t2_busy_after_done", 32'(busy[0]), 32'd0);
    repeat (20) @(negedge clk);
    chk("t2_done_once", 32'(done_cnt[0] - n0), 32'd1);

    // Varied plaintext; a start issued during STREAM must be ignored
    step(1);
    n0 = done_cnt[0];
    do_start(0, 16'd4);
    step(40);
    do_start(0, 16'd7);
    send_pt(0, 8'h5A, 8'hFA);
    send_pt(0, 8'h3C, 8'h9D);
    send_pt(0, 8'hFF, 8'h5D);
    send_pt(0, 8'h81, 8'h22);
    wait_done(0, "t_ign_done");
    repeat (20) @(negedge clk);
    chk("t_ign_idle", 32'(busy[0]), 32'd0);
    chk("t_ign_done_once", 32'(done_cnt[0] - n0), 32'd1);

    // FIFO overflow while plaintext is withheld
    step(1);
    do_start(0, 16'd4);
    ok = 1'b0;
    for (int t = 0; t < 300 && !ok; t++) begin
      @(negedge clk);
      if (g_stub[0].idx == 8'd4) ok = 1'b1;
    end
    chk("t4_four_bytes_seen", 32'(ok), 32'd1);
    chk("t4_ovf_before", 32'(ks_ovf[0]), 32'd0);
    ok = 1'b0;
    for (int t = 0; t < 300 && !ok; t++) begin
      @(negedge clk);
      if (g_stub[0].idx == 8'd5) ok = 1'b1;
    end
    chk("t4_ovf_after", 32'(ks_ovf[0]), 32'd1);
    step(1);
    send_pt(0, 8'h10, 8'hB0);
    send_pt(0, 8'h20, 8'h81);
    send_pt(0, 8'h30, 8'h92);
    send_pt(0, 8'h40, 8'hE3);
    wait_done(0, "t4_done");
    chk("t4_ovf_sticky", 32'(ks_ovf[0]), 32'd1);

    // ct back-pressure: data held, no new plaintext accepted
    step(1);
    ct_ready[0] = 1'b0;
    do_start(0, 16'd3);
    @(negedge clk);
    chk("t5_ovf_cleared", 32'(ks_ovf[0]), 32'd0);
    step(1);
    fork
      begin
        send_pt(0, 8'h01, 8'hA1);
        send_pt(0, 8'h02, 8'hA3);
        send_pt(0, 8'h04, 8'hA6);
      end
      begin
        bit seen;
        seen = 1'b0;
        for (int t = 0; t < 300 && !seen; t++) begin
          @(negedge clk);
          if (ct_valid[0] === 1'b1) seen = 1'b1;
        end
        chk("t5_ct_valid_seen", 32'(seen), 32'd1);
        for (int c = 0; c < 10; c++) begin
          chk("t5_stall_data", 32'(ct_data[0]), 32'hA1);
          chk("t5_stall_pt_ready", 32'(pt_ready[0]), 32'd0);
          @(negedge clk);
        end
        @(posedge clk);
        #2;
        ct_ready[0] = 1'b1;
      end
    join
    wait_done(0, "t5_done");

    // Zero-length message
    step(1);
    do_start(0, 16'd0);
    @(negedge clk);
    chk("t6_zero_done", 32'(done[0]), 32'd1);
    chk("t6_zero_core_rst_n", 32'(core_rst_n[0]), 32'd0);
    chk("t6_zero_busy", 32'(busy[0]), 32'd0);
    @(negedge clk);
    chk("t6_zero_done_pulse", 32'(done[0]), 32'd0);

    // Asynchronous reset in the middle of LOAD
    step(1);
    do_start(0, 16'd5);
    ok = 1'b0;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      if (core_rst_n[0] === 1'b1) ok = 1'b1;
    end
    repeat (5) @(negedge clk);
    chk("t6_mid_load_din", 32'(core_din[0]), 32'h05);
    #1;
    reset_n = 1'b0;
    #1;
    chk_reset(0, "t6_rst");
    step(1);
    reset_n = 1'b1;

    // DISCARD=2 instance: first two keystream bytes are dropped
    step(2);
    do_start(1, 16'd1);
    send_pt(1, 8'h11, 8'hB3);
    wait_done(1, "t3_done");
    repeat (20) @(negedge clk);
    chk("t3_ct_count", 32'(ct_cnt[1]), 32'd1);

    chk("q0_empty", 32'(exp0.size()), 32'd0);
    chk("q1_empty", 32'(exp1.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
